// File: rtl/bram_byte_seq_ctrl_pkg.sv
// rtl/bram_byte_seq_ctrl_pkg.sv - size/state encodings and byte-count helper for the BRAM byte sequencer
package bram_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } seq_state_t;

  // Reserved size 3 behaves like a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bram_byte_seq_ctrl_if.sv
// rtl/bram_byte_seq_ctrl_if.sv - request/response/BRAM-port bundle for the BRAM byte sequencer
interface bram_byte_seq_ctrl_if #(
  parameter int ADDR_W = 12
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // Requester plus BRAM side.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/bram_byte_seq_ctrl_load_ext.sv
// rtl/bram_byte_seq_ctrl_load_ext.sv - combinational sign/zero extender for byte/half/word loads
module bram_load_ext
  import bram_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Replicate the top bit of the loaded field unless the load is unsigned.
  always_comb begin
    ext = raw;
    case (size)
      SZ_B:    ext = {{24{raw[7]  & ~load_unsigned}}, raw[7:0]};
      SZ_H:    ext = {{16{raw[15] & ~load_unsigned}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/bram_byte_seq_ctrl.sv
// rtl/bram_byte_seq_ctrl.sv - byte-serial BRAM load/store sequencer (define MISALIGN_CHK_EN to reject misaligned half/word)
module bram_byte_seq_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  bram_byte_seq_ctrl_if.slave bus
);

  if (DATA_W != 32) begin : g_data_w_chk
    $error("bram_byte_seq_ctrl: DATA_W must be 32");
  end

  seq_state_t        state_q, state_d;

  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       raw_q, raw_d;
  logic              latch;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [2:0]        nbytes;
  logic              last;
  logic [1:0]        nxt;
  logic [1:0]        cap_lane;
  logic [31:0]       raw_cap;
  logic [31:0]       ext_data;
  logic              misalign;

  assign nbytes = size_bytes(size_q);
  assign last   = ({1'b0, cnt_q} == (nbytes - 3'd1));
  assign nxt    = cnt_q + 2'd1;

  // In ACCESS the byte arriving now was issued one cycle earlier; DRAIN brings the final byte.
  assign cap_lane = (state_q == DRAIN) ? cnt_q : (cnt_q - 2'd1);

`ifdef MISALIGN_CHK_EN
  assign misalign = ((bus.req_size == SZ_H) && bus.req_addr[0]) ||
                    (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Merge the incoming read byte into its little-endian lane.
  always_comb begin
    raw_cap = raw_q;
    raw_cap[{cap_lane, 3'b000} +: 8] = bus.mem_rdata;
  end

  bram_load_ext u_ext (
    .size          (size_q),
    .load_unsigned (uns_q),
    .raw           (raw_cap),
    .ext           (ext_data)
  );

  // Next-state and next-register values; mem_* only ever come from registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    raw_d       = raw_q;
    latch       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          latch   = 1'b1;
          cnt_d   = 2'd0;
          raw_d   = 32'd0;
          rdata_d = 32'd0;
          if (misalign) begin
            state_d = RESP;
          end else begin
            state_d     = ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata[7:0];
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 2'd0) begin
          raw_d = raw_cap;
        end
        if (last) begin
          state_d = we_q ? RESP : DRAIN;
        end else begin
          cnt_d       = nxt;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          mem_wdata_d = wdata_q[{nxt, 3'b000} +: 8];
        end
      end
      DRAIN: begin
        raw_d   = raw_cap;
        rdata_d = ext_data;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: latched request, byte counter, read accumulator and BRAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_B;
      wdata_q     <= 32'd0;
      cnt_q       <= 2'd0;
      raw_q       <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      rdata_q     <= 32'd0;
    end else begin
      if (latch) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        wdata_q <= bus.req_wdata;
      end
      cnt_q       <= cnt_d;
      raw_q       <= raw_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef MISALIGN_CHK_EN
  logic err_q;

  // Error flag is set only by a rejected request and cleared on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == IDLE) && bus.req_valid) begin
      err_q <= misalign;
    end else if ((state_q == RESP) && bus.rsp_ready) begin
      err_q <= 1'b0;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_bram_byte_seq_ctrl.sv
// tb/tb_bram_byte_seq_ctrl.sv - randomized self-checking bench for bram_byte_seq_ctrl
module tb_bram_byte_seq_ctrl;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

`ifdef MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bram_byte_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  bram_byte_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  bram    [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  int          cyc      = 0;
  int          en_total = 0;
  logic [11:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int          wr_cyc_q  [$];

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] h;
    h = 32'(i) * 32'd2654435761;
    return h[23:16] ^ h[7:0];
  endfunction

  // BRAM port B model (read-first, registered read) plus write/enable monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= init_byte(i);
    end else if (bus.mem_en) begin
      en_total <= en_total + 1;
      if (bus.mem_we) begin
        bram[bus.mem_addr] <= bus.mem_wdata;
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_wdata);
        wr_cyc_q.push_back(cyc);
      end
      bus.mem_rdata <= bram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction: drives the request, checks timing, data, port activity and backpressure.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rd);
    int          nb, lat, exp_lat, base_w, base_en;
    logic        mis;
    logic [31:0] v, held;
    logic [11:0] a;
    logic        held_err;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = CHK_EN && (((sz == 2'd1) && addr[0]) || ((sz >= 2'd2) && (addr[1:0] != 2'b00)));
    v = 32'd0;
    if (!mis && !we) begin
      for (int k = 0; k < nb; k++) begin
        a = addr + 12'(k);
        v = v | (32'(ref_mem[a]) << (8 * k));
      end
      if (nb == 1 && !uns && v >= 32'd128)   v = v + 32'hFFFF_FF00;
      if (nb == 2 && !uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
    exp_lat = mis ? 1 : (we ? nb + 1 : nb + 2);
    base_w  = wr_addr_q.size();
    base_en = en_total;

    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    bus.rsp_ready    = (hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 12'($urandom);
    bus.req_wdata = $urandom;
    bus.req_we    = 1'($urandom);
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", bus.rsp_rdata, v);
    check("rsp_err", 32'(bus.rsp_err), 32'(mis));
    held     = bus.rsp_rdata;
    held_err = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", bus.rsp_rdata, held);
      check("hold_err", 32'(bus.rsp_err), 32'(held_err));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_mem_en", 32'(bus.mem_en), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("rsp_done", 32'(bus.rsp_valid), 32'd0);
    check("back_idle", 32'(bus.req_ready), 32'd1);
    check("mem_en_cycles", 32'(en_total - base_en), mis ? 32'd0 : 32'(nb));
    check("write_count", 32'(wr_addr_q.size() - base_w), (we && !mis) ? 32'(nb) : 32'd0);
    if (we && !mis && (wr_addr_q.size() - base_w == nb)) begin
      for (int k = 0; k < nb; k++) begin
        a = addr + 12'(k);
        check("wr_addr", 32'(wr_addr_q[base_w + k]), 32'(a));
        check("wr_data", 32'(wr_data_q[base_w + k]), 32'(wdata[8 * k +: 8]));
        check("wr_cycle", 32'(wr_cyc_q[base_w + k] - wr_cyc_q[base_w]), 32'(k));
        ref_mem[a] = wdata[8 * k +: 8];
      end
    end
    rd = held;
  endtask

  initial begin
    logic [31:0] rd;
    int          base_w;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = 32'd0;
    bus.rsp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 2'd2, 1'b0, 12'h100, 32'hDEAD_BEEF, 0, rd);
    do_req(1'b0, 2'd2, 1'b0, 12'h100, 32'd0, 0, rd);
    check("lw_100", rd, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd0, 1'b0, 12'h103, 32'd0, 1, rd);
    check("lb_103", rd, 32'hFFFF_FFDE);
    do_req(1'b0, 2'd0, 1'b1, 12'h103, 32'd0, 0, rd);
    check("lbu_103", rd, 32'h0000_00DE);
    do_req(1'b0, 2'd1, 1'b0, 12'h102, 32'd0, 0, rd);
    check("lh_102", rd, 32'hFFFF_DEAD);
    do_req(1'b0, 2'd1, 1'b1, 12'h100, 32'd0, 3, rd);
    check("lhu_100", rd, 32'h0000_BEEF);
    do_req(1'b1, 2'd2, 1'b0, 12'hFFE, 32'h1122_3344, 0, rd);
    do_req(1'b0, 2'd2, 1'b0, 12'hFFE, 32'd0, 3, rd);
    do_req(1'b0, 2'd2, 1'b0, 12'h101, 32'd0, 2, rd);
    do_req(1'b0, 2'd1, 1'b0, 12'h102, 32'd0, 0, rd);
    do_req(1'b1, 2'd3, 1'b0, 12'h7FC, 32'hCAFE_F00D, 1, rd);
    do_req(1'b0, 2'd3, 1'b1, 12'h7FC, 32'd0, 0, rd);

    // Reset in the middle of a word store: only byte 0 reaches memory.
    base_w = wr_addr_q.size();
    @(posedge clk); #1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 12'h200;
    bus.req_wdata = 32'hA1B2_C3D4;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #3;
    check("mid_mem_en_before", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_mem_en", 32'(bus.mem_en), 32'd0);
    check("async_req_ready", 32'(bus.req_ready), 32'd1);
    check("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("async_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("partial_writes", 32'(wr_addr_q.size() - base_w), 32'd1);
    ref_mem[12'h200] = 8'hD4;
    do_req(1'b0, 2'd0, 1'b0, 12'h200, 32'd0, 0, rd);
    check("lb_after_rst", rd, 32'hFFFF_FFD4);
    do_req(1'b0, 2'd0, 1'b1, 12'h201, 32'd0, 0, rd);

    for (int t = 0; t < 150; t++) begin
      logic [11:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 12'(DEPTH - 1 - $urandom_range(0, 3)) : 12'($urandom);
      do_req(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, $urandom_range(0, 3), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
